// File: rtl/hls_regbank_pkg.sv
// ---------------------------------------------------------------
// hls_regbank_pkg : shared types for the shadow register bank
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package hls_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } commit_state_t;

  function automatic int be_w(input int width);
    return width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hls_be_register.sv
// ---------------------------------------------------------------
// hls_be_register : one register with byte-enable write and full load
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module hls_be_register
  import hls_regbank_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [be_w(WIDTH)-1:0]   be,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_data,
  output logic [WIDTH-1:0]         q
);

  // A full load wins over a byte write in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= INIT_VALUE;
    end else if (load) begin
      q <= load_data;
    end else if (we) begin
      for (int i = 0; i < be_w(WIDTH); i++) begin
        if (be[i]) q[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hls_shadow_register_bank.sv
// ---------------------------------------------------------------
// hls_shadow_register_bank : double-buffered control registers, frame-synced commit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module hls_shadow_register_bank
  import hls_regbank_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               NUM_REGS      = 8,
  parameter int               ADDR_W        = 3,
  parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
  parameter bit               DOUBLE_BUFFER = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write_en,
  input  logic [ADDR_W-1:0]         write_addr,
  input  logic [WIDTH-1:0]          write_data,
  input  logic [be_w(WIDTH)-1:0]    write_be,
  input  logic                      commit_req,
  input  logic                      frame_sync,
  input  logic [ADDR_W-1:0]         read_addr,
  output logic [WIDTH-1:0]          read_data,
  output logic [NUM_REGS*WIDTH-1:0] active_flat,
  output logic                      commit_pending,
  output logic                      commit_done
);

  commit_state_t state, state_next;
  logic [WIDTH-1:0] shadow_q [NUM_REGS];
  logic [WIDTH-1:0] active_q [NUM_REGS];
  logic             commit_load;
  logic [WIDTH-1:0] read_mux;

  // Only a frame_sync seen while armed copies shadow into active.
  assign commit_load = DOUBLE_BUFFER && (state == ARMED) && frame_sync;

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
      logic write_hit;
      assign write_hit = write_en && (write_addr == ADDR_W'(k));

      hls_be_register #(.WIDTH(WIDTH), .INIT_VALUE(INIT_VALUE)) u_shadow (
        .clk(clk), .reset(reset), .we(write_hit), .be(write_be), .wdata(write_data),
        .load(1'b0), .load_data(write_data), .q(shadow_q[k])
      );

      if (DOUBLE_BUFFER) begin : g_db
        hls_be_register #(.WIDTH(WIDTH), .INIT_VALUE(INIT_VALUE)) u_active (
          .clk(clk), .reset(reset), .we(1'b0), .be(write_be), .wdata(write_data),
          .load(commit_load), .load_data(shadow_q[k]), .q(active_q[k])
        );
      end else begin : g_direct
        hls_be_register #(.WIDTH(WIDTH), .INIT_VALUE(INIT_VALUE)) u_active (
          .clk(clk), .reset(reset), .we(write_hit), .be(write_be), .wdata(write_data),
          .load(1'b0), .load_data(write_data), .q(active_q[k])
        );
      end

      assign active_flat[k*WIDTH +: WIDTH] = active_q[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (commit_req) state_next = DOUBLE_BUFFER ? ARMED : DONE;
      ARMED:   if (frame_sync) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign commit_pending = (state == ARMED);
  assign commit_done    = (state == DONE);

  // Addresses past NUM_REGS fall through to zero.
  always_comb begin
    read_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (read_addr == ADDR_W'(k)) read_mux = active_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) read_data <= INIT_VALUE;
    else       read_data <= read_mux;
  end

endmodule

`default_nettype wire

// File: tb/tb_hls_shadow_register_bank.sv
// ---------------------------------------------------------------
// tb_hls_shadow_register_bank : directed vectors for the shadow register bank
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_hls_shadow_register_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_en = 1'b0;
  logic [2:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_be = '0;
  logic        commit_req = 1'b0;
  logic        frame_sync = 1'b0;
  logic [2:0]  read_addr = '0;

  logic [31:0]  rd_a, rd_b, rd_c;
  logic [255:0] flat_a;
  logic [191:0] flat_b;
  logic [255:0] flat_c;
  logic         pend_a, pend_b, pend_c, done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hls_shadow_register_bank dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_be(write_be), .commit_req(commit_req),
    .frame_sync(frame_sync), .read_addr(read_addr), .read_data(rd_a),
    .active_flat(flat_a), .commit_pending(pend_a), .commit_done(done_a)
  );

  hls_shadow_register_bank #(.NUM_REGS(6)) dut6 (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_be(write_be), .commit_req(commit_req),
    .frame_sync(frame_sync), .read_addr(read_addr), .read_data(rd_b),
    .active_flat(flat_b), .commit_pending(pend_b), .commit_done(done_b)
  );

  hls_shadow_register_bank #(.DOUBLE_BUFFER(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_be(write_be), .commit_req(commit_req),
    .frame_sync(frame_sync), .read_addr(read_addr), .read_data(rd_c),
    .active_flat(flat_c), .commit_pending(pend_c), .commit_done(done_c)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_a(input int k);
    return flat_a[k*32 +: 32];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    write_en = 1'b1; write_addr = a; write_data = d; write_be = b;
    step();
    write_en = 1'b0;
  endtask

  task automatic do_commit();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("commit_done_pulse", {31'd0, done_a}, 32'd1);
    step();
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'h11223344, 4'b1111, 3'd0, 32'h11223344};
    vecs[1] = '{3'd0, 32'hAABBCCDD, 4'b1000, 3'd0, 32'hAA223344};
    vecs[2] = '{3'd3, 32'hFFFFFFFF, 4'b0110, 3'd3, 32'h00FFFF00};
    vecs[3] = '{3'd3, 32'h12345678, 4'b0000, 3'd3, 32'h00FFFF00};
    vecs[4] = '{3'd7, 32'hDEADBEEF, 4'b1111, 3'd7, 32'hDEADBEEF};
    vecs[5] = '{3'd5, 32'h000000A5, 4'b0001, 3'd5, 32'h000000A5};
    vecs[6] = '{3'd1, 32'hCAFEBABE, 4'b0011, 3'd0, 32'hAA223344};

    // 1: reset values on readback
    do_reset();
    check("reset_pending", {31'd0, pend_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      read_addr = 3'(i);
      step();
      check("reset_read", rd_a, 32'h0);
    end

    // 2: byte-enabled write held until frame_sync
    do_write(3'd2, 32'hAABBCCDD, 4'b0101);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check("t2_hold_active", act_a(2), 32'h0);
      check("t2_pending", {31'd0, pend_a}, 32'd1);
    end
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("t2_active", act_a(2), 32'h00BB00DD);
    check("t2_done", {31'd0, done_a}, 32'd1);
    step();
    check("t2_done_drop", {31'd0, done_a}, 32'd0);
    check("t2_pending_drop", {31'd0, pend_a}, 32'd0);

    // 3: commit_req with frame_sync in IDLE only arms
    do_write(3'd4, 32'h00000077, 4'b1111);
    commit_req = 1'b1; frame_sync = 1'b1;
    step();
    commit_req = 1'b0; frame_sync = 1'b0;
    check("t3_no_update", act_a(4), 32'h0);
    check("t3_pending", {31'd0, pend_a}, 32'd1);
    check("t3_no_done", {31'd0, done_a}, 32'd0);
    step();
    step();
    check("t3_pending_hold", {31'd0, pend_a}, 32'd1);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("t3_active", act_a(4), 32'h00000077);
    check("t3_done", {31'd0, done_a}, 32'd1);
    step();

    // 4: write coincident with committing frame_sync stays in shadow
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    write_en = 1'b1; write_addr = 3'd1; write_data = 32'h5; write_be = 4'b1111;
    frame_sync = 1'b1;
    step();
    write_en = 1'b0; frame_sync = 1'b0;
    check("t4_old_active", act_a(1), 32'h0);
    check("t4_done", {31'd0, done_a}, 32'd1);
    step();
    do_commit();
    check("t4_second_commit", act_a(1), 32'h5);

    // Table: write, commit, read back
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      do_commit();
      read_addr = vecs[i].raddr;
      step();
      check($sformatf("vec%0d_read", i), rd_a, vecs[i].exp);
      check($sformatf("vec%0d_flat", i), act_a(int'(vecs[i].raddr)), vecs[i].exp);
    end

    // 5: out-of-range address on a 6-register bank
    do_reset();
    do_write(3'd7, 32'hFFFFFFFF, 4'b1111);
    do_commit();
    check("t5_flat_lo", flat_b[31:0], 32'h0);
    check("t5_flat_hi", flat_b[191:160], 32'h0);
    check("t5_flat_or", {31'd0, |flat_b}, 32'd0);
    read_addr = 3'd7;
    step();
    check("t5_read_oob", rd_b, 32'h0);

    // 6: reset while armed drops the commit and clears shadow
    do_reset();
    do_write(3'd2, 32'h00001234, 4'b1111);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    check("t6_armed", {31'd0, pend_a}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_pending_clr", {31'd0, pend_a}, 32'd0);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("t6_no_done", {31'd0, done_a}, 32'd0);
    check("t6_active_clr", act_a(2), 32'h0);
    do_commit();
    check("t6_shadow_clr", act_a(2), 32'h0);

    // Single-buffered bank: write visible immediately, commit_req goes straight to DONE
    do_write(3'd3, 32'hA5A5A5A5, 4'b1111);
    check("nb_active", flat_c[3*32 +: 32], 32'hA5A5A5A5);
    check("nb_db_not_active", act_a(3), 32'h0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    check("nb_done", {31'd0, done_c}, 32'd1);
    check("nb_pending", {31'd0, pend_c}, 32'd0);
    step();
    check("nb_done_drop", {31'd0, done_c}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
